ifetch_unit: RTL and testbench

- Instruction fetch front end: the initiator side of the instruction-memory read interface.
- Holds the fetch PC and drives the word address to the instruction memory, whose read data (4 little-endian bytes assembled) returns combinationally in the same cycle.
- Registers each fetched word, with its PC, into a small prefetch queue.
- Presents queue entries to decode over a valid/ready handshake; accepts branch/jump redirects that flush the queue.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_queue.sv | 58 +++++
 rtl/ifetch_unit.sv | 96 +++++++++
 tb/tb_ifetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package ifetch_pkg;

  localparam int XLEN             = 32;
  localparam int ILEN             = 32;
  localparam int INSTR_ALIGN_BITS = 2;

  // Low address bits that must be zero for a word-aligned instruction fetch
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INSTR_ALIGN_BITS) - 1);

  // One prefetch queue slot: the fetched word tagged with its address
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // True when a fetch target is not on an instruction word boundary
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & ALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO for the fetch unit. Pointers carry an extra wrap bit so
// full and empty fall out of a pointer compare. A push into a full queue is
// accepted when a pop happens on the same edge: the slot being written is
// the one the head is leaving.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rptr[AW-1:0]];

  // Advance the read/write pointers; a flush empties the queue outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Store pushed entries; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads instruction memory,
// buffers fetched words in ifetch_queue and hands them to decode over a
// valid/ready handshake. Redirects flush the queue and retarget the PC;
// a misaligned redirect target latches a sticky fault that halts fetching.
// Optional macro IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] iaddr,
  input  logic [ILEN-1:0] idata,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_fault
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  logic [XLEN-1:0] pc;
  logic            q_full;
  logic            q_empty;
  logic            fetch_ok;
  logic            push;
  logic            pop;
  fetch_entry_t    q_head;
  fetch_entry_t    new_entry;

  assign iaddr     = pc;
  assign out_valid = !q_empty && !redirect_valid;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;
  assign pop       = out_valid && out_ready;
  assign fetch_ok  = fetch_en && !misalign_fault && !redirect_valid;
  assign push      = fetch_ok && (!q_full || pop);
  assign new_entry = '{pc: pc, instr: idata};

  // Fetch PC: redirect wins, otherwise step one word per accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
    end else if (push) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Sticky fault: set by a misaligned redirect, cleared only by an aligned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_fault <= 1'b0;
    end else if (redirect_valid) begin
      misalign_fault <= is_misaligned(redirect_pc);
    end
  end

  ifetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_entry(new_entry),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

`ifdef IFETCH_PERF_EN
  // Count accepted fetches and cycles lost to a full queue; redirect keeps them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (fetch_ok && q_full && !pop) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit (DEPTH = 4, RESET_PC = 0).
// Each table row is one clock cycle: inputs are driven after the falling
// edge and outputs are compared before the next rising edge.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_fault;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int tests;
  int fails;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expIaddr;
    logic        expFault;
  } vec_t;

  vec_t vecs[$];

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iaddr         (iaddr),
    .idata         (idata),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .misalign_fault(misalign_fault)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: a fixed word at 0, an address-derived pattern elsewhere
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [7:0] b [4];
    if (addr == 32'h0) begin
      b[0] = 8'h93; b[1] = 8'h00; b[2] = 8'hA0; b[3] = 8'h00;
    end else begin
      b[0] = addr[7:0] ^ 8'h5A;
      b[1] = addr[15:8] ^ 8'hC3;
      b[2] = addr[23:16] ^ 8'h3C;
      b[3] = addr[31:24] ^ 8'hA5;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Memory responds combinationally to the fetch address
  always_comb idata = memWord(iaddr);

  task automatic addVec(input logic fe, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic ev,
                        input logic [31:0] epc, input logic [31:0] eia,
                        input logic ef);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.expValid = ev; v.expPc = epc; v.expIaddr = eia; v.expFault = ef;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    fetch_en       = v.fe;
    out_ready      = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v.expValid));
    checkOutput({tag, " iaddr"}, iaddr, v.expIaddr);
    checkOutput({tag, " misalign_fault"}, 32'(misalign_fault), 32'(v.expFault));
    if (v.expValid) begin
      checkOutput({tag, " out_pc"}, out_pc, v.expPc);
      checkOutput({tag, " out_instr"}, out_instr, memWord(v.expPc));
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Stall with out_ready low: four pushes fill the queue, iaddr stops at 16
    addVec(1, 0, 0, 0, 0, 32'h0,  32'h00, 0);
    addVec(1, 0, 0, 0, 1, 32'h0,  32'h04, 0);
    addVec(1, 0, 0, 0, 1, 32'h0,  32'h08, 0);
    addVec(1, 0, 0, 0, 1, 32'h0,  32'h0C, 0);
    for (int i = 0; i < 6; i++) addVec(1, 0, 0, 0, 1, 32'h0, 32'h10, 0);
    // Single-cycle ready on a full queue: pop and push on the same edge
    addVec(1, 1, 0, 0, 1, 32'h0,  32'h10, 0);
    addVec(1, 0, 0, 0, 1, 32'h4,  32'h14, 0);
    addVec(1, 0, 0, 0, 1, 32'h4,  32'h14, 0);
    // Drain in order while fetching every cycle
    addVec(1, 1, 0, 0, 1, 32'h4,  32'h14, 0);
    addVec(1, 1, 0, 0, 1, 32'h8,  32'h18, 0);
    addVec(1, 1, 0, 0, 1, 32'hC,  32'h1C, 0);
    // Redirect to 0x100: out_valid masked, queue flushed
    addVec(1, 1, 1, 32'h100, 0, 32'h0,   32'h20,  0);
    addVec(1, 1, 0, 0,       0, 32'h0,   32'h100, 0);
    addVec(1, 1, 0, 0,       1, 32'h100, 32'h104, 0);
    addVec(1, 1, 0, 0,       1, 32'h104, 32'h108, 0);
    // Misaligned redirect: fault latches, fetch halts at 0x100
    addVec(1, 1, 1, 32'h102, 0, 32'h0, 32'h10C, 0);
    for (int i = 0; i < 5; i++) addVec(1, 1, 0, 0, 0, 32'h0, 32'h100, 1);
    // Aligned redirect clears the fault and resumes at 0x200
    addVec(1, 1, 1, 32'h200, 0, 32'h0,   32'h100, 1);
    addVec(1, 1, 0, 0,       0, 32'h0,   32'h200, 0);
    addVec(1, 1, 0, 0,       1, 32'h200, 32'h204, 0);
    // fetch_en low: PC holds, queued entry still drains
    addVec(0, 0, 0, 0, 1, 32'h204, 32'h208, 0);
    addVec(0, 1, 0, 0, 1, 32'h204, 32'h208, 0);
    addVec(0, 1, 0, 0, 0, 32'h0,   32'h208, 0);
    // PC wrap across 2^32
    addVec(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         32'h208,       0);
    addVec(1, 1, 0, 0,             0, 32'h0,         32'hFFFF_FFF8, 0);
    addVec(1, 1, 0, 0,             1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0);
    addVec(1, 1, 0, 0,             1, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    addVec(1, 1, 0, 0,             1, 32'h0000_0000, 32'h0000_0004, 0);
    addVec(1, 1, 0, 0,             1, 32'h0000_0004, 32'h0000_0008, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset iaddr", iaddr, 32'h0);
    checkOutput("reset out_pc", out_pc, 32'h0);
    checkOutput("reset out_instr", out_instr, 32'h0);
    checkOutput("reset misalign_fault", 32'(misalign_fault), 32'h0);
`ifdef IFETCH_PERF_EN
    checkOutput("reset perf_fetched", perf_fetched, 32'h0);
    checkOutput("reset perf_stall", perf_stall, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkRow(i, vecs[i]);
    end

    // Let the last row's edge land before reading the counters
    @(negedge clk);
    #1;
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetched total", perf_fetched, 32'd18);
    checkOutput("perf_stall total", perf_stall, 32'd8);
`endif

    // Asynchronous reset in the middle of a cycle with entries queued
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'h0);
    checkOutput("midreset iaddr", iaddr, 32'h0);
    checkOutput("midreset misalign_fault", 32'(misalign_fault), 32'h0);
    checkOutput("midreset out_pc", out_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    checkOutput("midreset perf_fetched", perf_fetched, 32'h0);
`endif

    // First fetch after release appears one cycle later
    @(negedge clk);
    rst_n          = 1'b1;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    #1;
    checkOutput("release out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("first out_valid", 32'(out_valid), 32'h1);
    checkOutput("first out_pc", out_pc, 32'h0);
    checkOutput("first out_instr", out_instr, 32'h00A0_0093);
    checkOutput("first iaddr", iaddr, 32'h4);
    @(negedge clk);
    #1;
    checkOutput("second out_pc", out_pc, 32'h4);
    checkOutput("second iaddr", iaddr, 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
